sram_pdp_be: RTL and testbench
==============================

SRAM_PDP_BE -- requirements
Module: sram_pdp_be

Interface
REQ-001 Parameter depth, default 1024, number of words (any value >= 2, need not be a power of two).
REQ-002 Parameter width, default 16, word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter rd_lat, default 1, read latency in clocks; legal values 1 or 2; others SHALL fail elaboration.
REQ-004 Parameter wr_first, default 1; 1 = collision read returns new data, 0 = returns old data.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 cs  input  1  chip select; gates launch of new reads and writes.
REQ-008 we_A  input  1  port A write request.
REQ-009 be_A  input  width/8  port A byte enables, bit i covers data_inA[8i+7:8i].
REQ-010 add_A  input  $clog2(depth)  port A write address.
REQ-011 data_inA  input  width  port A write data.
REQ-012 re_B  input  1  port B read request.
REQ-013 add_B  input  $clog2(depth)  port B read address.
REQ-014 data_outB  output  width  port B read data, registered.
REQ-015 valid_B  output  1  one-cycle strobe, data_outB carries a new read result.

Function
REQ-016 Write SHALL occur at rising edge when cs=1, we_A=1, add_A<depth; only bytes with be_A bit set SHALL change.
REQ-017 we_A=1 with be_A all-zero SHALL leave memory unchanged.
REQ-018 Read launched at edge N (cs=1, re_B=1) SHALL drive data_outB and valid_B=1 after edge N+rd_lat.
REQ-019 valid_B SHALL be high exactly one cycle per launched read; back-to-back reads SHALL give one result per cycle, full throughput.
REQ-020 data_outB SHALL hold its last value while valid_B=0.
REQ-021 add_A>=depth write SHALL be dropped; add_B>=depth read SHALL complete with valid_B=1 and data 0.
REQ-022 Collision (read and write same edge, add_A==add_B): wr_first=1 returns merged word (enabled bytes new, others old); wr_first=0 returns full old word.
REQ-023 Write at edge N+1 to the address of a read launched at edge N (rd_lat=2) SHALL NOT alter that read's result.
REQ-024 cs=0 SHALL block new reads and writes; reads already in flight SHALL complete normally.
REQ-025 Read path SHALL be a shift pipeline of depth rd_lat carrying valid bit and data; no stalls, no backpressure.

Reset
REQ-026 On rst_n=0: data_outB=0, valid_B=0, all pipeline valid bits cleared, asynchronously.
REQ-027 Memory array SHALL NOT be reset; contents are unknown until written.
REQ-028 Reads in flight at reset assertion SHALL be discarded; no valid_B after release for them.
REQ-029 Writes presented while rst_n=0 SHALL be ignored; first operation accepted at first rising edge with rst_n=1.

Structure
REQ-030 Package sram_pkg SHALL hold the byte-width constant 8, legal rd_lat bounds, and a function for byte-merge of old/new words under an enable mask.
REQ-031 Storage and byte-masked write SHALL live in sub-module sram_pdp_array (no reset, one write port, one combinational read port); sram_pdp_be holds collision logic, read pipeline, and outputs.

Verification
REQ-032 Reset, write add_A=12 data 16'hABCD be=2'b11, read add_B=12 -> data_outB=16'hABCD with valid_B exactly rd_lat clocks after launch.
REQ-033 Write 16'h1234 at 100, then be=2'b10 data 16'hFF00 at 100, read 100 -> 16'hFF34.
REQ-034 Same-edge write 16'h5555 be=2'b01 and read at 7 holding 16'hAAAA -> wr_first=1 gives 16'hAA55, wr_first=0 gives 16'hAAAA.
REQ-035 Reads of 0,1,2,3 on consecutive edges (rd_lat=2) -> four consecutive valid_B pulses in order; rst_n pulsed low mid-burst -> valid_B=0, data_outB=0, no further pulses.
REQ-036 depth=1000: write to 1010 then read 1010 -> valid_B=1, data_outB=0; read 999 unaffected. cs=0 with re_B=1 -> no valid_B.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and the byte-merge helper for the pseudo-dual-port byte-enable SRAM.
package sram_pkg;

  localparam int BYTE_W     = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_W    = 1024;

  typedef logic [MERGE_W-1:0]        merge_word_t;
  typedef logic [MERGE_W/BYTE_W-1:0] merge_be_t;

  function automatic merge_word_t byte_merge(
    input merge_word_t old_word,
    input merge_word_t new_word,
    input merge_be_t   be
  );
    merge_word_t res;
    res = old_word;
    for (int i = 0; i < MERGE_W/BYTE_W; i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_pdp_array.sv
// Storage array: one byte-masked write port, one combinational read port, no reset.
module sram_pdp_array
  import sram_pkg::*;
#(
  parameter int depth = 1024,
  parameter int width = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(depth)-1:0] wr_addr,
  input  logic [width/BYTE_W-1:0]  wr_be,
  input  logic [width-1:0]         wr_data,
  input  logic [$clog2(depth)-1:0] rd_addr,
  output logic [width-1:0]         rd_data
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(depth);

  logic [width-1:0] mem [depth];
  logic             wr_hit;
  logic             rd_hit;
  logic [width-1:0] wr_old;
  logic [width-1:0] wr_merged;

  // Addresses past the last word are legal inputs when depth is not a power of two.
  assign wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_V);
  assign rd_hit = {1'b0, rd_addr} < DEPTH_V;

  always_comb begin
    wr_old = '0;
    if (wr_hit) wr_old = mem[wr_addr];
  end

  assign wr_merged = width'(byte_merge(merge_word_t'(wr_old),
                                       merge_word_t'(wr_data),
                                       merge_be_t'(wr_be)));

  always_comb begin
    rd_data = '0;
    if (rd_hit) rd_data = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_hit) mem[wr_addr] <= wr_merged;
  end

endmodule

// File: rtl/sram_pdp_be.sv
// Pseudo-dual-port SRAM with byte enables: write on port A, pipelined read on port B.
module sram_pdp_be
  import sram_pkg::*;
#(
  parameter int depth    = 1024,
  parameter int width    = 16,
  parameter int rd_lat   = 1,
  parameter int wr_first = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cs,
  input  logic                     we_A,
  input  logic [width/BYTE_W-1:0]  be_A,
  input  logic [$clog2(depth)-1:0] add_A,
  input  logic [width-1:0]         data_inA,
  input  logic                     re_B,
  input  logic [$clog2(depth)-1:0] add_B,
  output logic [width-1:0]         data_outB,
  output logic                     valid_B
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(depth);

  if (rd_lat < RD_LAT_MIN || rd_lat > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("sram_pdp_be: rd_lat must be 1 or 2");
  end
  if (width % BYTE_W != 0 || width > MERGE_W) begin : g_bad_width
    $error("sram_pdp_be: width must be a multiple of 8 and fit the merge helper");
  end
  if (depth < 2) begin : g_bad_depth
    $error("sram_pdp_be: depth must be at least 2");
  end

  logic             wr_en;
  logic             launch;
  logic             rd_in_range;
  logic             collide;
  logic [width-1:0] arr_rd;
  logic [width-1:0] rd_word;

  logic [rd_lat-1:0] pipe_vld;
  logic [width-1:0]  pipe_data [rd_lat];

  // Writes seen while reset is low must not land in the unreset array.
  assign wr_en       = rst_n && cs && we_A;
  assign launch      = cs && re_B;
  assign rd_in_range = {1'b0, add_B} < DEPTH_V;
  assign collide     = wr_en && (add_A == add_B);

  sram_pdp_array #(
    .depth(depth),
    .width(width)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(add_A),
    .wr_be  (be_A),
    .wr_data(data_inA),
    .rd_addr(add_B),
    .rd_data(arr_rd)
  );

  // Array read is pre-write; write-first collisions fold the incoming bytes in here.
  always_comb begin
    rd_word = arr_rd;
    if (!rd_in_range) begin
      rd_word = '0;
    end else if (collide && wr_first != 0) begin
      rd_word = width'(byte_merge(merge_word_t'(arr_rd),
                                  merge_word_t'(data_inA),
                                  merge_be_t'(be_A)));
    end
  end

  // Data is captured at launch, so later writes cannot disturb a read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int k = 0; k < rd_lat; k++) pipe_data[k] <= '0;
    end else begin
      pipe_vld[0] <= launch;
      if (launch) pipe_data[0] <= rd_word;
      for (int k = 1; k < rd_lat; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  assign data_outB = pipe_data[rd_lat-1];
  assign valid_B   = pipe_vld[rd_lat-1];

endmodule

// File: tb/tb_sram_pdp_be.sv
// Directed bench: two instances (rd_lat=2 write-first, rd_lat=1 read-first) share stimulus.
module tb_sram_pdp_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        we_A;
  logic [1:0]  be_A;
  logic [9:0]  add_A;
  logic [15:0] data_inA;
  logic        re_B;
  logic [9:0]  add_B;
  logic [15:0] dout_a, dout_b;
  logic        vld_a, vld_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_pdp_be #(.depth(1000), .width(16), .rd_lat(2), .wr_first(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_A(we_A), .be_A(be_A), .add_A(add_A),
    .data_inA(data_inA), .re_B(re_B), .add_B(add_B), .data_outB(dout_a), .valid_B(vld_a)
  );

  sram_pdp_be #(.depth(1000), .width(16), .rd_lat(1), .wr_first(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_A(we_A), .be_A(be_A), .add_A(add_A),
    .data_inA(data_inA), .re_B(re_B), .add_B(add_B), .data_outB(dout_b), .valid_B(vld_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
    we_A = 1'b1; add_A = a; data_inA = d; be_A = be;
    step();
    we_A = 1'b0;
  endtask

  task automatic launch_rd(input logic [9:0] a);
    re_B = 1'b1; add_B = a;
    step();
    re_B = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b0; we_A = 1'b0; re_B = 1'b0;
    be_A = '0; add_A = '0; add_B = '0; data_inA = '0;
    repeat (2) step();
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_vld_a: got %b want 0", vld_a); end
    checks++; if (dout_a !== 16'h0) begin errors++; $display("FAIL reset_dout_a: got %h want 0000", dout_a); end
    checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL reset_vld_b: got %b want 0", vld_b); end
    checks++; if (dout_b !== 16'h0) begin errors++; $display("FAIL reset_dout_b: got %h want 0000", dout_b); end
    rst_n = 1'b1; cs = 1'b1;
  endtask

  task automatic test_basic();
    wr(10'd12, 16'hABCD, 2'b11);
    launch_rd(10'd12);
    checks++; if (vld_b !== 1'b1) begin errors++; $display("FAIL basic_vld_b: got %b want 1", vld_b); end
    checks++; if (dout_b !== 16'hABCD) begin errors++; $display("FAIL basic_dout_b: got %h want abcd", dout_b); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL basic_vld_a_early: got %b want 0", vld_a); end
    step();
    checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL basic_vld_a: got %b want 1", vld_a); end
    checks++; if (dout_a !== 16'hABCD) begin errors++; $display("FAIL basic_dout_a: got %h want abcd", dout_a); end
    checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL basic_vld_b_once: got %b want 0", vld_b); end
    checks++; if (dout_b !== 16'hABCD) begin errors++; $display("FAIL basic_hold_b: got %h want abcd", dout_b); end
    step();
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL basic_vld_a_once: got %b want 0", vld_a); end
    checks++; if (dout_a !== 16'hABCD) begin errors++; $display("FAIL basic_hold_a: got %h want abcd", dout_a); end
  endtask

  task automatic test_byte_enable();
    wr(10'd100, 16'h1234, 2'b11);
    wr(10'd100, 16'hFF00, 2'b10);
    wr(10'd100, 16'hDEAD, 2'b00);
    launch_rd(10'd100);
    checks++; if (dout_b !== 16'hFF34) begin errors++; $display("FAIL be_dout_b: got %h want ff34", dout_b); end
    step();
    checks++; if (dout_a !== 16'hFF34) begin errors++; $display("FAIL be_dout_a: got %h want ff34", dout_a); end
  endtask

  task automatic test_collision();
    wr(10'd7, 16'hAAAA, 2'b11);
    we_A = 1'b1; add_A = 10'd7; data_inA = 16'h5555; be_A = 2'b01;
    re_B = 1'b1; add_B = 10'd7;
    step();
    we_A = 1'b0; re_B = 1'b0;
    checks++; if (dout_b !== 16'hAAAA) begin errors++; $display("FAIL coll_old_b: got %h want aaaa", dout_b); end
    step();
    checks++; if (dout_a !== 16'hAA55) begin errors++; $display("FAIL coll_new_a: got %h want aa55", dout_a); end
    launch_rd(10'd7);
    checks++; if (dout_b !== 16'hAA55) begin errors++; $display("FAIL coll_after_b: got %h want aa55", dout_b); end
    step();
    checks++; if (dout_a !== 16'hAA55) begin errors++; $display("FAIL coll_after_a: got %h want aa55", dout_a); end
  endtask

  task automatic test_write_after_launch();
    re_B = 1'b1; add_B = 10'd100;
    step();
    re_B = 1'b0;
    checks++; if (dout_b !== 16'hFF34) begin errors++; $display("FAIL hazard_b: got %h want ff34", dout_b); end
    wr(10'd100, 16'h0BAD, 2'b11);
    checks++; if (vld_a !== 1'b1 || dout_a !== 16'hFF34) begin errors++; $display("FAIL hazard_a: got %b/%h want 1/ff34", vld_a, dout_a); end
    launch_rd(10'd100);
    checks++; if (dout_b !== 16'h0BAD) begin errors++; $display("FAIL hazard_new_b: got %h want 0bad", dout_b); end
    step();
    checks++; if (dout_a !== 16'h0BAD) begin errors++; $display("FAIL hazard_new_a: got %h want 0bad", dout_a); end
  endtask

  task automatic test_out_of_range();
    wr(10'd999, 16'h9999, 2'b11);
    wr(10'd1010, 16'h1111, 2'b11);
    wr(10'd1000, 16'h2222, 2'b11);
    launch_rd(10'd1010);
    checks++; if (vld_b !== 1'b1 || dout_b !== 16'h0) begin errors++; $display("FAIL oor1010_b: got %b/%h want 1/0000", vld_b, dout_b); end
    step();
    checks++; if (vld_a !== 1'b1 || dout_a !== 16'h0) begin errors++; $display("FAIL oor1010_a: got %b/%h want 1/0000", vld_a, dout_a); end
    launch_rd(10'd1000);
    checks++; if (vld_b !== 1'b1 || dout_b !== 16'h0) begin errors++; $display("FAIL oor1000_b: got %b/%h want 1/0000", vld_b, dout_b); end
    step();
    checks++; if (vld_a !== 1'b1 || dout_a !== 16'h0) begin errors++; $display("FAIL oor1000_a: got %b/%h want 1/0000", vld_a, dout_a); end
    launch_rd(10'd999);
    checks++; if (dout_b !== 16'h9999) begin errors++; $display("FAIL last_word_b: got %h want 9999", dout_b); end
    step();
    checks++; if (dout_a !== 16'h9999) begin errors++; $display("FAIL last_word_a: got %h want 9999", dout_a); end
  endtask

  task automatic test_chip_select();
    cs = 1'b0; re_B = 1'b1; add_B = 10'd7;
    we_A = 1'b1; add_A = 10'd7; data_inA = 16'h0000; be_A = 2'b11;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++; if (vld_a !== 1'b0 || vld_b !== 1'b0) begin errors++; $display("FAIL cs_block_%0d: got %b/%b want 0/0", s, vld_a, vld_b); end
    end
    cs = 1'b1; re_B = 1'b0; we_A = 1'b0;
    launch_rd(10'd7);
    checks++; if (dout_b !== 16'hAA55) begin errors++; $display("FAIL cs_nowrite_b: got %h want aa55", dout_b); end
    step();
    checks++; if (dout_a !== 16'hAA55) begin errors++; $display("FAIL cs_nowrite_a: got %h want aa55", dout_a); end
    re_B = 1'b1; add_B = 10'd999;
    step();
    cs = 1'b0;
    checks++; if (vld_b !== 1'b1 || dout_b !== 16'h9999) begin errors++; $display("FAIL inflight_b: got %b/%h want 1/9999", vld_b, dout_b); end
    step();
    checks++; if (vld_a !== 1'b1 || dout_a !== 16'h9999) begin errors++; $display("FAIL inflight_a: got %b/%h want 1/9999", vld_a, dout_a); end
    checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL inflight_b_gated: got %b want 0", vld_b); end
    step();
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL inflight_a_gated: got %b want 0", vld_a); end
    cs = 1'b1; re_B = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) wr(10'(i), 16'(16'h1000 + i), 2'b11);
    for (int s = 0; s < 6; s++) begin
      if (s < 4) begin re_B = 1'b1; add_B = 10'(s); end
      else re_B = 1'b0;
      step();
      if (s < 4) begin
        checks++; if (vld_b !== 1'b1 || dout_b !== 16'(16'h1000 + s)) begin errors++; $display("FAIL b2b_b_%0d: got %b/%h want 1/%h", s, vld_b, dout_b, 16'(16'h1000 + s)); end
      end else begin
        checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL b2b_b_end_%0d: got %b want 0", s, vld_b); end
      end
      if (s >= 1 && s <= 4) begin
        checks++; if (vld_a !== 1'b1 || dout_a !== 16'(16'h0FFF + s)) begin errors++; $display("FAIL b2b_a_%0d: got %b/%h want 1/%h", s, vld_a, dout_a, 16'(16'h0FFF + s)); end
      end else begin
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL b2b_a_idle_%0d: got %b want 0", s, vld_a); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    re_B = 1'b1; add_B = 10'd0;
    step();
    add_B = 10'd1;
    step();
    add_B = 10'd2;
    rst_n = 1'b0;
    #1;
    checks++; if (vld_a !== 1'b0 || dout_a !== 16'h0) begin errors++; $display("FAIL rst_async_a: got %b/%h want 0/0000", vld_a, dout_a); end
    checks++; if (vld_b !== 1'b0 || dout_b !== 16'h0) begin errors++; $display("FAIL rst_async_b: got %b/%h want 0/0000", vld_b, dout_b); end
    we_A = 1'b1; add_A = 10'd0; data_inA = 16'hFFFF; be_A = 2'b11;
    step();
    checks++; if (vld_a !== 1'b0 || vld_b !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b/%b want 0/0", vld_a, vld_b); end
    we_A = 1'b0; re_B = 1'b0;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++; if (vld_a !== 1'b0 || vld_b !== 1'b0) begin errors++; $display("FAIL rst_discard_%0d: got %b/%b want 0/0", s, vld_a, vld_b); end
    end
    launch_rd(10'd0);
    checks++; if (dout_b !== 16'h1000) begin errors++; $display("FAIL rst_nowrite_b: got %h want 1000", dout_b); end
    step();
    checks++; if (dout_a !== 16'h1000) begin errors++; $display("FAIL rst_nowrite_a: got %h want 1000", dout_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enable();
    test_collision();
    test_write_after_launch();
    test_out_of_range();
    test_chip_select();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
